// File: rtl/abc_sweep_checker.sv
// Sweeps A,B,C through all eight input vectors, samples the returned Y after a settle
// window, and reports the captured truth table against an expected one.
module abc_sweep_checker #(
  parameter int unsigned SETTLE = 4,
  parameter logic [7:0]  EXPECT = 8'h42
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Y_IN,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [7:0] TT,
  output logic [3:0] ERR_CNT,
  output logic [2:0] FIRST_ERR
);

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  tt_q, tt_d;
  logic [3:0]  err_cnt_q, err_cnt_d;
  logic [2:0]  first_err_q, first_err_d;
  logic        pass_q, pass_d;
  logic        mismatch;

  assign mismatch = (Y_IN != EXPECT[idx_q]);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tt_d        = tt_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    unique case (state_q)
      StIdle, StFin: begin
        if (START) begin
          state_d     = StRun;
          idx_d       = 3'd0;
          cnt_d       = 4'd0;
          tt_d        = 8'h00;
          err_cnt_d   = 4'd0;
          first_err_d = 3'd0;
          pass_d      = 1'b0;
        end
      end
      StRun: begin
        if (cnt_q != SettleLast) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          tt_d[idx_q] = Y_IN;
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 4'd1;
            // First mismatch of the sweep is the only one recorded.
            if (err_cnt_q == 4'd0) first_err_d = idx_q;
          end
          cnt_d = 4'd0;
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
          end else begin
            state_d = StFin;
            idx_d   = 3'd0;
            pass_d  = (err_cnt_d == 4'd0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      idx_q       <= 3'd0;
      cnt_q       <= 4'd0;
      tt_q        <= 8'h00;
      err_cnt_q   <= 4'd0;
      first_err_q <= 3'd0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tt_q        <= tt_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign A         = idx_q[2];
  assign B         = idx_q[1];
  assign C         = idx_q[0];
  assign BUSY      = (state_q == StRun);
  assign DONE      = (state_q == StFin);
  assign PASS      = pass_q;
  assign TT        = tt_q;
  assign ERR_CNT   = err_cnt_q;
  assign FIRST_ERR = first_err_q;

endmodule

// File: tb/tb_abc_sweep_checker.sv
// Scoreboard bench for abc_sweep_checker: two instances (SETTLE=4 and SETTLE=1) driven
// against a modelled combinational block with ideal, stuck-at-0 and stuck-at-1 behaviour.
module tb_abc_sweep_checker;

  typedef struct {
    logic [7:0] tt;
    logic [3:0] err_cnt;
    logic [2:0] first_err;
    logic       pass;
    int         lat;
  } res_t;

  localparam int Limit = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  int   sel, mode;
  int   checks, errors;
  res_t sb_q[$];

  logic       start4, start1, y4, y1;
  logic       a4, b4, c4, busy4, done4, pass4;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [7:0] tt4, tt1;
  logic [3:0] err4, err1;
  logic [2:0] first4, first1;

  logic [2:0] o_abc, o_first;
  logic       o_busy, o_done, o_pass;
  logic [7:0] o_tt;
  logic [3:0] o_err;

  logic       busy0, done0, pass0;
  logic [7:0] tt0;
  logic [2:0] abc_log[64];

  function automatic logic ymodel(input logic [2:0] v, input int m);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      default: return (!v[2] && !v[1] && v[0]) || (v[2] && v[1] && !v[0]);
    endcase
  endfunction

  function automatic res_t model_exp(input int m, input int settle);
    res_t       r;
    logic [7:0] mism;
    logic [7:0] expect_tt;
    expect_tt   = 8'h42;
    r.err_cnt   = 4'd0;
    r.first_err = 3'd0;
    for (int i = 0; i < 8; i++) r.tt[i] = ymodel(3'(i), m);
    mism = r.tt ^ expect_tt;
    for (int i = 7; i >= 0; i--) begin
      if (mism[i]) begin
        r.err_cnt   = r.err_cnt + 4'd1;
        r.first_err = 3'(i);
      end
    end
    r.pass = (r.err_cnt == 4'd0);
    r.lat  = 8 * settle;
    return r;
  endfunction

  assign start4 = start && (sel == 0);
  assign start1 = start && (sel == 1);
  assign y4     = ymodel({a4, b4, c4}, mode);
  assign y1     = ymodel({a1, b1, c1}, mode);

  abc_sweep_checker #(.SETTLE(4), .EXPECT(8'h42)) u_dut4 (
    .CLK(clk), .RST(rst), .START(start4), .Y_IN(y4), .A(a4), .B(b4), .C(c4),
    .BUSY(busy4), .DONE(done4), .PASS(pass4), .TT(tt4), .ERR_CNT(err4), .FIRST_ERR(first4)
  );

  abc_sweep_checker #(.SETTLE(1), .EXPECT(8'h42)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start1), .Y_IN(y1), .A(a1), .B(b1), .C(c1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .TT(tt1), .ERR_CNT(err1), .FIRST_ERR(first1)
  );

  always_comb begin
    o_abc   = {a4, b4, c4};
    o_busy  = busy4;
    o_done  = done4;
    o_pass  = pass4;
    o_tt    = tt4;
    o_err   = err4;
    o_first = first4;
    if (sel == 1) begin
      o_abc   = {a1, b1, c1};
      o_busy  = busy1;
      o_done  = done1;
      o_pass  = pass1;
      o_tt    = tt1;
      o_err   = err1;
      o_first = first1;
    end
  end

  // Pulses START, pushes the expected result, then waits (bounded) for DONE.
  // n counts clock edges after the START edge; outputs are sampled on the falling edge.
  task automatic run_sweep(input int pulse_at, output res_t obs);
    int n;
    @(negedge clk);
    start = 1'b1;
    sb_q.push_back(model_exp(mode, (sel == 1) ? 1 : 4));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy0 = o_busy; done0 = o_done; pass0 = o_pass; tt0 = o_tt;
    abc_log[0] = o_abc;
    while (!o_done && n < Limit) begin
      if (n == pulse_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n < 64) abc_log[n] = o_abc;
    end
    obs.tt = o_tt; obs.err_cnt = o_err; obs.first_err = o_first; obs.pass = o_pass;
    obs.lat = n;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      checks++;
      if ({o_abc, o_busy, o_done, o_pass, o_tt, o_err, o_first} !== 24'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d got %h want 0", s,
                 {o_abc, o_busy, o_done, o_pass, o_tt, o_err, o_first});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep(input string name, input int s, input int m, input int pulse_at);
    res_t obs, exp;
    sel = s; mode = m;
    run_sweep(pulse_at, obs);
    exp = sb_q.pop_front();
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL %s busy got %b want 1", name, busy0); end
    if (s == 0 && m == 0) begin
      for (int n = 0; n < 32; n++) begin
        checks++;
        if (abc_log[n] !== 3'(n / 4)) begin
          errors++;
          $display("FAIL %s abc@%0d got %0d want %0d", name, n, abc_log[n], n / 4);
        end
      end
    end
    checks += 5;
    if (obs.lat !== exp.lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, obs.lat, exp.lat);
    end
    if (obs.tt !== exp.tt) begin
      errors++; $display("FAIL %s tt got %h want %h", name, obs.tt, exp.tt);
    end
    if (obs.err_cnt !== exp.err_cnt) begin
      errors++; $display("FAIL %s err_cnt got %0d want %0d", name, obs.err_cnt, exp.err_cnt);
    end
    if (obs.first_err !== exp.first_err) begin
      errors++;
      $display("FAIL %s first_err got %0d want %0d", name, obs.first_err, exp.first_err);
    end
    if (obs.pass !== exp.pass) begin
      errors++; $display("FAIL %s pass got %b want %b", name, obs.pass, exp.pass);
    end
  endtask

  task automatic test_reset_mid_sweep();
    sel = 0; mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (o_abc !== 3'd5) begin errors++; $display("FAIL mid_idx got %0d want 5", o_abc); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({o_abc, o_busy, o_done, o_pass, o_tt, o_err} !== 21'h0) begin
      errors++;
      $display("FAIL mid_reset got %h want 0", {o_abc, o_busy, o_done, o_pass, o_tt, o_err});
    end
    test_sweep("after_reset", 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    test_sweep("settle1_first", 1, 0, -1);
    test_sweep("settle1_restart", 1, 0, -1);
    checks++;
    if ({done0, pass0, tt0} !== 10'h0) begin
      errors++;
      $display("FAIL restart_clear got done=%b pass=%b tt=%h want 0 0 00", done0, pass0, tt0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; sel = 0; mode = 0; rst = 1'b1; start = 1'b0;
    test_reset();
    test_sweep("ideal", 0, 0, -1);
    test_sweep("stuck0", 0, 1, -1);
    test_sweep("stuck1", 0, 2, -1);
    test_sweep("start_ignored", 0, 0, 12);
    test_reset_mid_sweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/abc_sweep_checker.md
Name: abc_sweep_checker

Overview:
- Sequential stimulus-and-check stage placed directly upstream of the 3-input combinational function block (mux-based Y = A'B'C + ABC').
- Drives A, B, C through all 8 input combinations and holds each for a settle window.
- Samples the returned Y into a captured truth table and compares it against an expected table.
- Reports pass/fail, mismatch count and the first failing index, for board LEDs or a bench.

Parameters:
- SETTLE, 4, cycles each vector is held before Y is sampled; legal range 1..15; 0 is illegal.
- EXPECT, 8'h42, expected truth table; bit i = expected Y for {A,B,C} = i (A is MSB).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  level-sampled request to begin a sweep.
- Y_IN  input  1  Y returned from the combinational block, same clock domain, no synchroniser.
- A  output  1  stimulus MSB, idx[2].
- B  output  1  stimulus, idx[1].
- C  output  1  stimulus LSB, idx[0].
- BUSY  output  1  high while a sweep is in progress.
- DONE  output  1  high from sweep completion until the next START or RST.
- PASS  output  1  valid only when DONE=1; 1 iff TT == EXPECT.
- TT  output  8  captured truth table; bit i = sampled Y for index i.
- ERR_CNT  output  4  number of mismatching indices, 0..8.
- FIRST_ERR  output  3  lowest mismatching index; 0 when ERR_CNT=0.

Behaviour:
- Registers: state {IDLE, RUN, FIN}; idx[2:0]; cnt[3:0]; TT; ERR_CNT; FIRST_ERR; PASS.
- A,B,C are taken directly from registered idx, so stimulus is glitch-free.
- Reset: when RST=1 at an edge, state=IDLE and idx, cnt, TT, ERR_CNT, FIRST_ERR are 0. Outputs are then A=B=C=0, BUSY=0, DONE=0, PASS=0. RST has priority over everything, including mid-sweep; no partial results are kept.
- IDLE: START=1 at an edge gives state=RUN, idx=0, cnt=0, and clears TT, ERR_CNT and FIRST_ERR.
- RUN, cnt < SETTLE-1: cnt increments; idx holds.
- RUN, cnt == SETTLE-1 (sample edge):
  - TT[idx] <= Y_IN.
  - If Y_IN != EXPECT[idx]: ERR_CNT increments; FIRST_ERR <= idx if this is the first mismatch of the sweep.
  - If idx < 7: idx increments and cnt <= 0.
  - If idx == 7: state <= FIN, idx <= 0, and PASS <= (ERR_CNT_next == 0), i.e. the final compare is included.
- Timing: each vector is presented for exactly SETTLE cycles, and Y is sampled on the last edge of that window. With SETTLE=1, Y is sampled on the edge after the vector is applied.
- Latency: with START seen at edge k, DONE rises after edge k+8*SETTLE. BUSY is high from edge k to edge k+8*SETTLE.
- FIN: DONE=1, BUSY=0, and TT, ERR_CNT, FIRST_ERR, PASS hold. START=1 restarts exactly as from IDLE, with DONE and PASS dropping on that edge.
- START while in RUN is ignored; a held-high START after FIN restarts immediately, which is by design.
- BUSY = (state==RUN); DONE = (state==FIN); both are decoded from registered state.
- ERR_CNT saturates naturally at 8; a 4-bit width is sufficient.

Test Plan:
- Ideal model Y = A'B'C + ABC', SETTLE=4, one-cycle START pulse → A,B,C step 000..111 every 4 cycles; DONE=1 exactly 32 cycles after START edge; TT=8'h42, PASS=1, ERR_CNT=0, FIRST_ERR=0.
- Y_IN stuck at 0 → TT=8'h00, ERR_CNT=2, FIRST_ERR=1, PASS=0.
- Y_IN stuck at 1 → TT=8'hFF, ERR_CNT=6, FIRST_ERR=0, PASS=0.
- Ideal model, START pulsed again while idx=3 and BUSY=1 → ignored; DONE still rises 32 cycles after the first START; results as in the ideal case.
- RST asserted for 1 cycle while idx=5 → next cycle A=B=C=0, BUSY=0, DONE=0, TT=0, ERR_CNT=0; a fresh START then completes normally with PASS=1.
- SETTLE=1 with ideal model, then a second START from FIN → DONE 8 cycles after each START; DONE and PASS clear on the restart edge and TT is rebuilt to 8'h42.
